lb2wb_master: RTL and testbench
===============================

Name: lb2wb_master

Overview:
- Localbus-to-Wishbone initiator bridge. Converts a single-cycle localbus read or write request into one classic Wishbone master cycle.
- Waits for ack_i, returns read data with a done pulse, and frees the localbus for the next request.
- Sits between a localbus-side control agent (CPU/host interface, PTP control sequencer) and the Wishbone fabric hosting the PTP register slave at 0x03000000–0x030000FF.

Parameters:
- TIMEOUT, 255: cycles in BUS state without ack_i before the cycle is aborted; legal 1–65535.
- TO_W, 16: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  asynchronous active-high reset
- req_wr  in  1  localbus write request pulse; sampled only when busy=0
- req_rd  in  1  localbus read request pulse; sampled only when busy=0
- req_addr  in  32  byte address
- req_data  in  32  write data
- busy  out  1  transaction in progress; new requests ignored
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = aborted by timeout
- rd_data  out  32  read result; holds until the next successful read
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  Wishbone write enable
- adr_o  out  32  Wishbone byte address
- dat_o  out  32  Wishbone write data
- dat_i  in  32  Wishbone read data
- ack_i  in  1  Wishbone acknowledge

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high. All registers clear immediately on rst_i=1: cyc_o, stb_o, we_o, busy, done, err = 0; adr_o, dat_o, rd_data = 0; FSM = IDLE; counter = 0.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - On an edge with busy=0 and (req_wr|req_rd): latch adr_o<=req_addr, dat_o<=req_data, we_o<=req_wr.
  - Same edge: cyc_o=stb_o=busy=1, counter cleared, go to BUS.
  - req_wr and req_rd together: treated as a write.
  - ack_i in IDLE is ignored.
- BUS:
  - cyc_o, stb_o, adr_o, dat_o, we_o held stable.
  - Counter increments each cycle.
  - On an edge with ack_i=1: cyc_o=stb_o=0; if we_o=0 then rd_data<=dat_i; go to DONE with done=1, err=0.
  - Else, when the counter reaches TIMEOUT-1: cyc_o=stb_o=0; go to DONE with done=1, err=1; rd_data unchanged.
  - ack_i and timeout on the same edge: ack wins, err=0.
- DONE (one cycle):
  - done=1 for exactly this cycle; busy=0 in this cycle.
  - Next edge: done=0, err=0, go to IDLE.
  - A request arriving during DONE is accepted (busy=0): next state BUS directly, done still drops.
- Requests while busy=1 are dropped silently; no queueing.
- Latency: request at edge 0 → stb_o high after edge 0. If ack_i is first sampled high at edge k, done is high after edge k for one cycle. With a registered-ack slave: done after edge 2, so 3 cycles request-to-done.
- rst_i mid-transaction: cycle abandoned, cyc_o/stb_o drop asynchronously, no done pulse.

Optional Feature:
- Macro: LB2WB_TIMEOUT_EN.
- Defined: timeout counter and err path as described above.
- Undefined: no counter; BUS waits for ack_i indefinitely; err tied 0; TIMEOUT and TO_W unused.

Test Plan:
- Write: req_wr pulse, addr 0x03000010, data 0xDEADBEEF; slave acks 1 cycle after stb → adr_o=0x03000010, dat_o=0xDEADBEEF, we_o=1 for 2 cycles; done=1, err=0 exactly once, 3 cycles after the request.
- Read: req_rd, addr 0x03000004; slave returns dat_i=0x12345678 with ack → rd_data=0x12345678 in the done cycle; we_o=0 throughout; rd_data holds after a subsequent write.
- Busy drop: second req_rd while busy=1 → no second cycle on cyc_o; a single done pulse. Back-to-back request in the DONE cycle → new stb_o on the next cycle.
- Timeout (LB2WB_TIMEOUT_EN, TIMEOUT=8): no ack → cyc_o high exactly 8 cycles, then done=1, err=1, rd_data unchanged. Ack on the 8th cycle → err=0.
- Simultaneous req_wr=req_rd=1 → we_o=1 write cycle.
- rst_i asserted mid-BUS → cyc_o/stb_o/busy low without waiting for a clock edge; no done pulse; the next request proceeds normally.

Source files
------------

// File: rtl/lb2wb_master.sv
// Localbus-to-Wishbone bridge: turns one localbus read/write pulse into a single classic Wishbone
// cycle. Define LB2WB_TIMEOUT_EN to abort cycles that see no ack_i within TIMEOUT cycles.
module lb2wb_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_wr,
    input  logic        req_rd,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rd_data,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        req_any;

`ifdef LB2WB_TIMEOUT_EN
    logic            err_q, err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            cnt_expired;

    assign cnt_expired = (cnt_q == TO_W'(TIMEOUT - 1));
`else
    logic unused_cfg;

    assign unused_cfg = ^{TIMEOUT[0], TO_W[0]};
`endif

    assign req_any = req_wr | req_rd;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rd_data_d = rd_data_q;
`ifdef LB2WB_TIMEOUT_EN
        err_d     = 1'b0;
        cnt_d     = cnt_q;
`endif

        unique case (state_q)
            // DONE behaves like IDLE for new requests since busy is already low.
            StIdle, StDone: begin
                state_d = StIdle;
                if (req_any) begin
                    state_d = StBus;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = req_wr;
                    busy_d  = 1'b1;
                    adr_d   = req_addr;
                    dat_d   = req_data;
`ifdef LB2WB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            StBus: begin
                if (ack_i) begin
                    state_d = StDone;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rd_data_d = dat_i;
                    end
                end
`ifdef LB2WB_TIMEOUT_EN
                else if (cnt_expired) begin
                    state_d = StDone;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
`endif
            end

            default: begin
                state_d = StIdle;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef LB2WB_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;
    assign cyc_o   = cyc_q;
    assign stb_o   = stb_q;
    assign we_o    = we_q;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;

    // Classic single-beat master: strobe always tracks cycle, and done never overlaps busy.
    a_cyc_stb: assert property (@(posedge clk_i) disable iff (rst_i) cyc_o == stb_o);
    a_done_idle: assert property (@(posedge clk_i) disable iff (rst_i) done |-> !busy);

endmodule

// File: tb/tb_lb2wb_master.sv
// Directed self-checking bench for lb2wb_master; timeout scenarios run when LB2WB_TIMEOUT_EN is set.
module tb_lb2wb_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_wr, req_rd;
    logic [31:0] req_addr, req_data;
    logic        busy, done, err;
    logic [31:0] rd_data;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o, dat_i;
    logic        ack_i;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int rise_cnt = 0;
    logic cyc_prev = 1'b0;

    lb2wb_master #(
        .TIMEOUT(8),
        .TO_W   (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_wr  (req_wr),
        .req_rd  (req_rd),
        .req_addr(req_addr),
        .req_data(req_data),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rd_data (rd_data),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Count done pulses and rising edges of cyc_o mid-cycle, away from the active edge.
    always @(negedge clk_i) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (cyc_o === 1'b1 && cyc_prev !== 1'b1) rise_cnt <= rise_cnt + 1;
        cyc_prev <= cyc_o;
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b0; req_wr = 0; req_rd = 0; req_addr = '0; req_data = '0;
        dat_i = '0; ack_i = 0;
        #1 rst_i = 1'b1;
        #1;
        n_cmp++; if ({cyc_o, stb_o, we_o, busy, done, err} !== 6'b0) begin
            n_err++; $display("FAIL rst_ctrl: got %b want 000000", {cyc_o, stb_o, we_o, busy, done, err});
        end
        n_cmp++; if ({adr_o, dat_o, rd_data} !== 96'h0) begin
            n_err++; $display("FAIL rst_data: got %h %h %h want zeros", adr_o, dat_o, rd_data);
        end
        tick(); tick();
        rst_i = 1'b0;
        // Stray ack while idle must not start or finish anything.
        ack_i = 1'b1; dat_i = 32'hFFFF_FFFF;
        tick(); tick();
        ack_i = 1'b0;
        n_cmp++; if ({cyc_o, busy, done, rd_data} !== 35'h0) begin
            n_err++; $display("FAIL idle_ack: got cyc=%b busy=%b done=%b rd=%h want 0", cyc_o, busy, done, rd_data);
        end
    endtask

    task automatic test_write;
        int d0;
        d0 = done_cnt;
        req_wr = 1; req_addr = 32'h0300_0010; req_data = 32'hDEAD_BEEF;
        tick();
        req_wr = 0; req_addr = '0; req_data = '0;
        n_cmp++; if ({cyc_o, stb_o, we_o, busy, done} !== 5'b11110) begin
            n_err++; $display("FAIL wr_start: got %b want 11110", {cyc_o, stb_o, we_o, busy, done});
        end
        n_cmp++; if (adr_o !== 32'h0300_0010 || dat_o !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL wr_bus: got adr=%h dat=%h want 03000010 deadbeef", adr_o, dat_o);
        end
        tick();
        n_cmp++; if ({cyc_o, we_o, done} !== 3'b110 || adr_o !== 32'h0300_0010) begin
            n_err++; $display("FAIL wr_hold: got cyc/we/done=%b adr=%h want 110 03000010", {cyc_o, we_o, done}, adr_o);
        end
        ack_i = 1; dat_i = 32'h7777_7777;
        tick();
        ack_i = 0;
        n_cmp++; if ({done, err, cyc_o, stb_o, busy} !== 5'b10000) begin
            n_err++; $display("FAIL wr_done: got %b want 10000", {done, err, cyc_o, stb_o, busy});
        end
        n_cmp++; if (rd_data !== 32'h0) begin
            n_err++; $display("FAIL wr_rd_keep: got %h want 00000000", rd_data);
        end
        tick();
        n_cmp++; if (done !== 1'b0 || done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL wr_pulse: got done=%b pulses=%0d want 0 1", done, done_cnt - d0);
        end
    endtask

    task automatic test_read;
        req_rd = 1; req_addr = 32'h0300_0004;
        tick();
        req_rd = 0;
        n_cmp++; if ({cyc_o, we_o, busy} !== 3'b101 || adr_o !== 32'h0300_0004) begin
            n_err++; $display("FAIL rd_start: got %b adr=%h want 101 03000004", {cyc_o, we_o, busy}, adr_o);
        end
        tick();
        n_cmp++; if (we_o !== 1'b0) begin
            n_err++; $display("FAIL rd_we: got %b want 0", we_o);
        end
        ack_i = 1; dat_i = 32'h1234_5678;
        tick();
        ack_i = 0; dat_i = '0;
        n_cmp++; if (done !== 1'b1 || rd_data !== 32'h1234_5678) begin
            n_err++; $display("FAIL rd_data: got done=%b rd=%h want 1 12345678", done, rd_data);
        end
        tick();
        // A following write must leave rd_data alone.
        req_wr = 1; req_addr = 32'h0300_0008; req_data = 32'h0000_00AA;
        tick();
        req_wr = 0;
        ack_i = 1; dat_i = 32'hFFFF_0000;
        tick();
        ack_i = 0;
        n_cmp++; if (done !== 1'b1 || rd_data !== 32'h1234_5678) begin
            n_err++; $display("FAIL rd_hold: got done=%b rd=%h want 1 12345678", done, rd_data);
        end
        tick();
    endtask

    task automatic test_busy_drop;
        int d0, r0;
        d0 = done_cnt; r0 = rise_cnt;
        req_rd = 1; req_addr = 32'h0300_0008;
        tick();
        req_addr = 32'h0300_0020;  // second request while busy
        tick();
        req_rd = 0;
        n_cmp++; if (adr_o !== 32'h0300_0008) begin
            n_err++; $display("FAIL drop_adr: got %h want 03000008", adr_o);
        end
        ack_i = 1; dat_i = 32'hA5A5_A5A5;
        tick();
        ack_i = 0;
        n_cmp++; if ({done, busy, cyc_o} !== 3'b100 || rd_data !== 32'hA5A5_A5A5) begin
            n_err++; $display("FAIL drop_done: got %b rd=%h want 100 a5a5a5a5", {done, busy, cyc_o}, rd_data);
        end
        n_cmp++; if (rise_cnt - r0 !== 1 || done_cnt - d0 !== 0) begin
            n_err++; $display("FAIL drop_once: got rises=%0d pulses=%0d want 1 0", rise_cnt - r0, done_cnt - d0);
        end
        // Back-to-back request placed in the DONE cycle.
        req_wr = 1; req_addr = 32'h0300_00F0; req_data = 32'h1122_3344;
        tick();
        req_wr = 0;
        n_cmp++; if ({done, cyc_o, stb_o, we_o, busy} !== 5'b01111 || adr_o !== 32'h0300_00F0) begin
            n_err++; $display("FAIL b2b: got %b adr=%h want 01111 030000f0", {done, cyc_o, stb_o, we_o, busy}, adr_o);
        end
        ack_i = 1;
        tick();
        ack_i = 0;
        n_cmp++; if (done !== 1'b1 || done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL b2b_done: got done=%b pulses=%0d want 1 1", done, done_cnt - d0);
        end
        tick();
    endtask

    task automatic test_simul;
        req_wr = 1; req_rd = 1; req_addr = 32'h0300_0030; req_data = 32'h0F0F_0F0F;
        tick();
        req_wr = 0; req_rd = 0;
        n_cmp++; if (we_o !== 1'b1 || dat_o !== 32'h0F0F_0F0F) begin
            n_err++; $display("FAIL simul_we: got we=%b dat=%h want 1 0f0f0f0f", we_o, dat_o);
        end
        ack_i = 1; dat_i = 32'h5555_5555;
        tick();
        ack_i = 0;
        n_cmp++; if (done !== 1'b1 || rd_data !== 32'hA5A5_A5A5) begin
            n_err++; $display("FAIL simul_rd: got done=%b rd=%h want 1 a5a5a5a5", done, rd_data);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int d0;
        d0 = done_cnt;
        req_rd = 1; req_addr = 32'h0300_0040;
        tick();
        req_rd = 0;
        #2 rst_i = 1;
        #1;
        n_cmp++; if ({cyc_o, stb_o, busy} !== 3'b000) begin
            n_err++; $display("FAIL rst_async: got %b want 000", {cyc_o, stb_o, busy});
        end
        ack_i = 1; dat_i = 32'h9999_9999;
        tick();
        ack_i = 0;
        tick();
        rst_i = 0;
        tick();
        n_cmp++; if (done !== 1'b0 || done_cnt - d0 !== 0) begin
            n_err++; $display("FAIL rst_nodone: got done=%b pulses=%0d want 0 0", done, done_cnt - d0);
        end
        req_rd = 1; req_addr = 32'h0300_0044;
        tick();
        req_rd = 0;
        ack_i = 1; dat_i = 32'hCAFE_F00D;
        tick();
        ack_i = 0;
        n_cmp++; if (done !== 1'b1 || rd_data !== 32'hCAFE_F00D) begin
            n_err++; $display("FAIL rst_next: got done=%b rd=%h want 1 cafef00d", done, rd_data);
        end
        tick();
    endtask

`ifdef LB2WB_TIMEOUT_EN
    task automatic test_timeout;
        int cyc_hi;
        req_rd = 1; req_addr = 32'h0300_0050;
        tick();
        req_rd = 0; dat_i = 32'h4444_4444;
        cyc_hi = 0;
        for (int i = 0; i < 40 && cyc_o === 1'b1; i++) begin
            cyc_hi++;
            tick();
        end
        n_cmp++; if (cyc_hi !== 8) begin
            n_err++; $display("FAIL to_len: got %0d cycles want 8", cyc_hi);
        end
        n_cmp++; if ({done, err} !== 2'b11 || rd_data !== 32'hCAFE_F00D) begin
            n_err++; $display("FAIL to_err: got done/err=%b rd=%h want 11 cafef00d", {done, err}, rd_data);
        end
        tick();
        n_cmp++; if ({done, err} !== 2'b00) begin
            n_err++; $display("FAIL to_clear: got %b want 00", {done, err});
        end
        // Ack sampled on the same edge the counter expires: ack wins.
        req_rd = 1;
        tick();
        req_rd = 0;
        for (int i = 0; i < 7; i++) tick();
        ack_i = 1; dat_i = 32'h0BAD_F00D;
        tick();
        ack_i = 0;
        n_cmp++; if ({done, err} !== 2'b10 || rd_data !== 32'h0BAD_F00D) begin
            n_err++; $display("FAIL to_ack: got done/err=%b rd=%h want 10 0badf00d", {done, err}, rd_data);
        end
        tick();
    endtask
`else
    task automatic test_no_timeout;
        req_rd = 1; req_addr = 32'h0300_0050;
        tick();
        req_rd = 0;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++; if ({cyc_o, busy, done, err} !== 4'b1100) begin
            n_err++; $display("FAIL wait_ack: got %b want 1100", {cyc_o, busy, done, err});
        end
        ack_i = 1; dat_i = 32'h0BAD_F00D;
        tick();
        ack_i = 0;
        n_cmp++; if ({done, err} !== 2'b10 || rd_data !== 32'h0BAD_F00D) begin
            n_err++; $display("FAIL late_ack: got done/err=%b rd=%h want 10 0badf00d", {done, err}, rd_data);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_busy_drop();
        test_simul();
        test_reset_mid();
`ifdef LB2WB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
